// File: rtl/nibble_bus_mem_pkg.sv
// Shared constants and FSM state type for the nibble bus memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nibble_mem_pkg;

    localparam int ADDR_W    = 6;                 // matches the CPU's 6-bit PC
    localparam int DATA_W    = 4;                 // nibble width
    localparam int FRAME_W   = ADDR_W + DATA_W;   // serial frame: addr then data
    localparam int MEM_DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // serve the CPU bus
        ST_LOAD   = 2'd1,   // shift in a host frame
        ST_COMMIT = 2'd2    // write the assembled frame into the array
    } state_e;

endpackage

// File: rtl/nibble_bus_mem_if.sv
// CPU bus plus host programming pins of the nibble memory.
// Latency: n/a (wires only).
// Backpressure: none; the host holds the CPU through cpu_hold while loading.
// master = CPU/host side (drives bus and serial loader), slave = memory side.
interface nibble_bus_mem_if;
    import nibble_mem_pkg::*;

    logic [ADDR_W-1:0] bus_in;     // address, or {2'b00, write data} when bus_wcyc=1
    logic              bus_wcyc;   // CPU write-cycle flag
    logic [DATA_W-1:0] rd_data;    // registered nibble back to the CPU
    logic              prog_en;    // host programming request
    logic              prog_sdi;   // serial frame bit, MSB first
    logic              cpu_hold;   // keeps the CPU in reset while programming
    logic              prog_done;  // one-cycle pulse per committed host word

    modport master (
        output bus_in, bus_wcyc, prog_en, prog_sdi,
        input  rd_data, cpu_hold, prog_done
    );

    modport slave (
        input  bus_in, bus_wcyc, prog_en, prog_sdi,
        output rd_data, cpu_hold, prog_done
    );

endinterface

// File: rtl/nibble_bus_mem_prog_shifter.sv
// Serial frame assembler: MSB-first shift register plus bit counter.
// Latency: bit lands in frame one edge after shift_en; frame_full flags the last bit.
// Backpressure: none; clr discards a partial frame.
// Ports: clk, rst_n (sync, active-low), clr, shift_en, sdi -> frame, frame_full.
module nibble_prog_shifter
    import nibble_mem_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               shift_en,
    input  logic               sdi,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_full
);

    localparam int CNT_W = $clog2(FRAME_W + 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] sr_q, sr_d;

    // High while the next shift completes the frame; independent of shift_en
    // so the parent FSM can use it without a combinational loop.
    assign frame_full = (cnt_q == CNT_W'(FRAME_W - 1));
    assign frame      = sr_q;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clr) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (shift_en) begin
            sr_d  = {sr_q[FRAME_W-2:0], sdi};
            // Counter restarts once the frame is complete; the data stays
            // in sr_q for the commit cycle.
            cnt_d = frame_full ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nibble_bus_mem.sv
// 64x4 program/data memory on the nibble CPU's multiplexed bus, with a serial host loader.
// Latency: read data registered, valid the cycle after the address; writes commit at the cycle's edge.
// Backpressure: none on the CPU bus; the host owns the array outside IDLE and holds the CPU meanwhile.
// Ports: clk, rst_n (sync, active-low), bus (nibble_bus_mem_if.slave).
module nibble_bus_mem
    import nibble_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    nibble_bus_mem_if.slave  bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              prog_done_q, prog_done_d;
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] mem_d [MEM_DEPTH];

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              shift_en;
    logic              shift_clr;
    logic [FRAME_W-1:0] frame;
    logic              frame_full;

    nibble_prog_shifter u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (shift_clr),
        .shift_en   (shift_en),
        .sdi        (bus.prog_sdi),
        .frame      (frame),
        .frame_full (frame_full)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_data_d = rd_data_q;
        we        = 1'b0;
        waddr     = addr_q;
        wdata     = bus.bus_in[DATA_W-1:0];
        shift_en  = 1'b0;
        shift_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // CPU bus is serviced even on the edge that enters LOAD.
                if (bus.bus_wcyc) begin
                    we = 1'b1;      // store goes to the last latched address
                end else begin
                    addr_d    = bus.bus_in;
                    rd_data_d = mem_q[bus.bus_in];
                end
                if (bus.prog_en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (bus.prog_en) begin
                    shift_en = 1'b1;
                    if (frame_full) state_d = ST_COMMIT;
                end else begin
                    shift_clr = 1'b1;   // drop the partial frame
                    state_d   = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                we      = 1'b1;
                waddr   = frame[FRAME_W-1:DATA_W];
                wdata   = frame[DATA_W-1:0];
                state_d = bus.prog_en ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        cpu_hold_d  = (state_d != ST_IDLE);
        prog_done_d = (state_q == ST_COMMIT);

        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rd_data_q   <= '0;
            cpu_hold_q  <= 1'b0;
            prog_done_q <= 1'b0;
            mem_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_data_q   <= rd_data_d;
            cpu_hold_q  <= cpu_hold_d;
            prog_done_q <= prog_done_d;
            mem_q       <= mem_d;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.prog_done = prog_done_q;

endmodule

// File: tb/tb_nibble_bus_mem.sv
// Self-checking bench for nibble_bus_mem: directed test-plan cases plus randomized traffic.
// Latency: expects read data one edge after the address; frame commit 11 edges after entry.
// Backpressure: bench drives the CPU bus only while the memory is not holding it.
module tb_nibble_bus_mem;

    logic clk;
    logic rst_n;

    nibble_bus_mem_if bus_if ();

    nibble_bus_mem dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: contents of the 64-word array, the CPU's latched
    // address, and the nibble the CPU should currently see.
    logic [3:0] model_mem [64];
    logic [5:0] cur_addr;
    logic [3:0] exp_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic park_bus();
        bus_if.bus_in   = cur_addr;
        bus_if.bus_wcyc = 1'b0;
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        bus_if.prog_en   = 1'b0;
        bus_if.prog_sdi  = 1'b0;
        bus_if.bus_in    = '0;
        bus_if.bus_wcyc  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) model_mem[i] = 4'h0;
        cur_addr = '0;
        exp_rd   = 4'h0;
        check("rst_rd",   32'(bus_if.rd_data),   32'd0);
        check("rst_hold", 32'(bus_if.cpu_hold),  32'd0);
        check("rst_done", 32'(bus_if.prog_done), 32'd0);
    endtask

    task automatic cpu_read(input logic [5:0] a);
        bus_if.bus_in   = a;
        bus_if.bus_wcyc = 1'b0;
        tick();
        cur_addr = a;
        exp_rd   = model_mem[a];
        check("rd_data",   32'(bus_if.rd_data),   32'(exp_rd));
        check("rd_hold",   32'(bus_if.cpu_hold),  32'd0);
        check("rd_done",   32'(bus_if.prog_done), 32'd0);
    endtask

    task automatic cpu_write(input logic [3:0] d);
        logic [1:0] up;
        up              = 2'($urandom);   // upper bus bits must be ignored
        bus_if.bus_in   = {up, d};
        bus_if.bus_wcyc = 1'b1;
        tick();
        model_mem[cur_addr] = d;
        check("wr_rd_hold", 32'(bus_if.rd_data), 32'(exp_rd));
        park_bus();
    endtask

    // One host word. first: enter LOAD from IDLE; last: drop prog_en at commit.
    task automatic host_frame(input logic [5:0] a, input logic [3:0] d,
                              input bit first, input bit last);
        logic [9:0] f;
        f = {a, d};
        bus_if.prog_en = 1'b1;
        if (first) begin
            tick();
            exp_rd = model_mem[cur_addr];
            check("hold_rise",   32'(bus_if.cpu_hold), 32'd1);
            check("rd_at_entry", 32'(bus_if.rd_data),  32'(exp_rd));
        end
        for (int i = 0; i < 10; i++) begin
            bus_if.prog_sdi = f[9-i];
            if (i == 0) begin
                bus_if.bus_in   = 6'h03;   // CPU store attempt while held
                bus_if.bus_wcyc = 1'b1;
            end else begin
                bus_if.bus_in   = 6'($urandom);
                bus_if.bus_wcyc = 1'($urandom);
            end
            tick();
            check("load_hold", 32'(bus_if.cpu_hold),  32'd1);
            check("load_done", 32'(bus_if.prog_done), 32'd0);
            check("load_rd",   32'(bus_if.rd_data),   32'(exp_rd));
        end
        bus_if.prog_en  = !last;
        bus_if.prog_sdi = 1'($urandom);   // not sampled in the commit cycle
        tick();
        model_mem[a] = d;
        check("commit_done", 32'(bus_if.prog_done), 32'd1);
        check("commit_hold", 32'(bus_if.cpu_hold),  32'(!last));
        check("commit_rd",   32'(bus_if.rd_data),   32'(exp_rd));
        park_bus();
    endtask

    task automatic abort_frame(input logic [5:0] a, input logic [3:0] d, input int nbits);
        logic [9:0] f;
        f = {a, d};
        bus_if.prog_en = 1'b1;
        tick();
        exp_rd = model_mem[cur_addr];
        for (int i = 0; i < nbits; i++) begin
            bus_if.prog_sdi = f[9-i];
            bus_if.bus_in   = 6'($urandom);
            bus_if.bus_wcyc = 1'($urandom);
            tick();
            check("abort_load_hold", 32'(bus_if.cpu_hold), 32'd1);
        end
        park_bus();
        bus_if.prog_en = 1'b0;
        tick();
        check("abort_hold", 32'(bus_if.cpu_hold),  32'd0);
        check("abort_done", 32'(bus_if.prog_done), 32'd0);
        check("abort_rd",   32'(bus_if.rd_data),   32'(exp_rd));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        do_reset();

        // Reads after reset
        cpu_read(6'h15);
        cpu_read(6'h00);

        // CPU store and read-back
        cpu_read(6'h2A);
        cpu_write(4'h7);
        cpu_read(6'h2A);
        check("raw_2a", 32'(bus_if.rd_data), 32'h7);
        cpu_read(6'h2B);
        check("neighbour_2b", 32'(bus_if.rd_data), 32'h0);

        // Single host frame 0x3F/0xC
        host_frame(6'h3F, 4'hC, 1'b1, 1'b1);
        cpu_read(6'h3F);
        check("host_3f", 32'(bus_if.rd_data), 32'hC);

        // Back-to-back frames
        host_frame(6'h01, 4'h5, 1'b1, 1'b0);
        host_frame(6'h02, 4'hA, 1'b0, 1'b1);
        cpu_read(6'h01);
        check("b2b_01", 32'(bus_if.rd_data), 32'h5);
        cpu_read(6'h02);
        check("b2b_02", 32'(bus_if.rd_data), 32'hA);

        // Aborted frame aimed at 0x2A leaves it alone
        abort_frame(6'h2A, 4'h1, 6);
        cpu_read(6'h2A);
        check("abort_keep_2a", 32'(bus_if.rd_data), 32'h7);

        // CPU store on the same edge prog_en rises, then a dropped store in LOAD
        cpu_read(6'h10);
        bus_if.bus_in   = {2'b00, 4'h9};
        bus_if.bus_wcyc = 1'b1;
        bus_if.prog_en  = 1'b1;
        tick();
        model_mem[6'h10] = 4'h9;
        check("edge_hold", 32'(bus_if.cpu_hold), 32'd1);
        park_bus();
        host_frame(6'h11, 4'h6, 1'b0, 1'b1);
        cpu_read(6'h10);
        check("edge_wr_10", 32'(bus_if.rd_data), 32'h9);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                cpu_read(6'($urandom));
            end else if (op <= 6) begin
                cpu_write(4'($urandom));
            end else if (op <= 8) begin
                if ($urandom_range(0, 1) == 1) begin
                    host_frame(6'($urandom), 4'($urandom), 1'b1, 1'b0);
                    host_frame(6'($urandom), 4'($urandom), 1'b0, 1'b1);
                end else begin
                    host_frame(6'($urandom), 4'($urandom), 1'b1, 1'b1);
                end
            end else begin
                abort_frame(6'($urandom), 4'($urandom), $urandom_range(0, 9));
            end
        end

        // Sweep the whole array against the model
        for (int a = 0; a < 64; a++) cpu_read(6'(a));

        // Reset in the middle of a frame clears everything
        bus_if.prog_en = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus_if.prog_sdi = 1'b1;
            tick();
        end
        do_reset();
        cpu_read(6'h3F);
        check("midrst_3f", 32'(bus_if.rd_data), 32'h0);
        cpu_read(6'h10);
        check("midrst_10", 32'(bus_if.rd_data), 32'h0);
        cpu_read(6'h2A);
        check("midrst_2a", 32'(bus_if.rd_data), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
